// File: rtl/myfilter_pkg.sv
// Shared definitions for the filter configuration path: I2C frame geometry,
// slave address and receive-sequencer state encoding.
package myfilter_pkg;

    localparam int I2C_DATA_BYTES  = 3;
    localparam int I2C_FRAME_BYTES = I2C_DATA_BYTES + 1;

    localparam logic [6:0] I2C_SLAVE_ADDR = 7'h4A;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        WAIT_STOP
    } i2c_rx_state_t;

endpackage

// File: rtl/i2c_ctr.sv
// Bit/byte counter shared by the I2C receive path: counts SCL rises within a byte
// and completed data bytes within a frame.
module i2c_ctr #(
    parameter int DATA_BYTES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic next_i,
    input  logic byteen_i,
    output logic byteok_o,
    output logic frameok_o
);

    localparam int CntW = (DATA_BYTES < 1) ? 1 : $clog2(DATA_BYTES + 1);

    logic [3:0]      bitCnt_q;
    logic [CntW-1:0] byteCnt_q;

    // A clear while byte counting is enabled only restarts the bit count, so the
    // byte total survives the data ACK slots; any other clear starts a new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitCnt_q  <= '0;
            byteCnt_q <= '0;
        end else if (clr_i) begin
            bitCnt_q <= '0;
            if (!byteen_i) begin
                byteCnt_q <= '0;
            end
        end else if (next_i) begin
            if (bitCnt_q != 4'd8) begin
                bitCnt_q <= bitCnt_q + 4'd1;
            end
            if (byteen_i && (bitCnt_q == 4'd7) && (byteCnt_q != CntW'(DATA_BYTES))) begin
                byteCnt_q <= byteCnt_q + CntW'(1);
            end
        end
    end

    assign byteok_o  = (bitCnt_q == 4'd8);
    assign frameok_o = (byteCnt_q == CntW'(DATA_BYTES));

endmodule

// File: rtl/i2c_rx_sequencer.sv
// Write-only I2C slave front end: synchronises the bus, matches the slave address,
// ACKs address and data bytes and delivers complete data frames.
module i2c_rx_sequencer
    import myfilter_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = I2C_SLAVE_ADDR,
    parameter int         DATA_BYTES  = I2C_DATA_BYTES,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    scl_in,
    input  logic                    sda_in,
    output logic                    sda_drive_out,
    output logic [8*DATA_BYTES-1:0] frame_out,
    output logic                    frame_valid_out,
    output logic                    frame_err_out,
    output logic                    busy_out
);

    localparam int FrameW = 8 * DATA_BYTES;

    logic [SYNC_STAGES-1:0] sclSync_q;
    logic [SYNC_STAGES-1:0] sdaSync_q;
    logic                   sclPrev_q;
    logic                   sdaPrev_q;

    logic sclS;
    logic sdaS;
    logic sclRise;
    logic sclFall;
    logic startEv;
    logic stopEv;

    i2c_rx_state_t     state_q;
    logic [7:0]        addrShift_q;
    logic [FrameW-1:0] frameShift_q;
    logic [FrameW-1:0] frame_q;
    logic              frameValid_q;
    logic              frameErr_q;
    logic              busy_q;
    logic              ack_q;
    logic              done_q;

    logic ctrClr;
    logic ctrNext;
    logic ctrByteen;
    logic byteok;
    logic frameok;
    logic partialFrame;

    // Synchronisers idle high so a reset never manufactures a bus edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclSync_q <= '1;
            sdaSync_q <= '1;
            sclPrev_q <= 1'b1;
            sdaPrev_q <= 1'b1;
        end else begin
            sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], scl_in};
            sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sda_in};
            sclPrev_q <= sclS;
            sdaPrev_q <= sdaS;
        end
    end

    assign sclS    = sclSync_q[SYNC_STAGES-1];
    assign sdaS    = sdaSync_q[SYNC_STAGES-1];
    assign sclRise = sclS & ~sclPrev_q;
    assign sclFall = ~sclS & sclPrev_q;
    assign startEv = sclS & sclPrev_q & sdaPrev_q & ~sdaS;
    assign stopEv  = sclS & sclPrev_q & ~sdaPrev_q & sdaS;

    assign ctrByteen = (state_q == DATA) || (state_q == DATA_ACK);
    assign ctrNext   = sclRise && ((state_q == ADDR) || (state_q == DATA));
    assign ctrClr    = startEv || (sclFall && ((state_q == ADDR_ACK) || (state_q == DATA_ACK)));

    // Only an address-matched transfer that has entered the data phase can be cut short.
    assign partialFrame = ctrByteen;

    i2c_ctr #(
        .DATA_BYTES(DATA_BYTES)
    ) u_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (ctrClr),
        .next_i   (ctrNext),
        .byteen_i (ctrByteen),
        .byteok_o (byteok),
        .frameok_o(frameok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addrShift_q  <= '0;
            frameShift_q <= '0;
            frame_q      <= '0;
            frameValid_q <= 1'b0;
            frameErr_q   <= 1'b0;
            busy_q       <= 1'b0;
            ack_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            frameValid_q <= 1'b0;
            frameErr_q   <= 1'b0;
            if (startEv) begin
                frameErr_q <= partialFrame;
                state_q    <= ADDR;
                ack_q      <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b0;
            end else if (stopEv) begin
                if ((state_q == WAIT_STOP) && done_q) begin
                    frame_q      <= frameShift_q;
                    frameValid_q <= 1'b1;
                end else begin
                    frameErr_q <= partialFrame;
                end
                state_q <= IDLE;
                ack_q   <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    ADDR: begin
                        if (byteok) begin
                            if (addrShift_q == {SLAVE_ADDR, 1'b0}) begin
                                state_q <= ADDR_ACK;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= WAIT_STOP;
                            end
                        end else if (sclRise) begin
                            addrShift_q <= {addrShift_q[6:0], sdaS};
                        end
                    end
                    DATA: begin
                        if (byteok) begin
                            state_q <= DATA_ACK;
                        end else if (sclRise) begin
                            frameShift_q <= {frameShift_q[FrameW-2:0], sdaS};
                        end
                    end
                    // First SCL fall opens the ACK slot, the second one closes it.
                    ADDR_ACK, DATA_ACK: begin
                        if (sclFall) begin
                            if (!ack_q) begin
                                ack_q <= 1'b1;
                            end else begin
                                ack_q <= 1'b0;
                                if ((state_q == DATA_ACK) && frameok) begin
                                    state_q <= WAIT_STOP;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q <= DATA;
                                end
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign sda_drive_out   = ack_q;
    assign frame_out       = frame_q;
    assign frame_valid_out = frameValid_q;
    assign frame_err_out   = frameErr_q;
    assign busy_out        = busy_q;

endmodule

// File: tb/tb_i2c_rx_sequencer.sv
// Bench for i2c_rx_sequencer: a bit-banged I2C master plus a scoreboard of
// expected frame/abort pulses.
module tb_i2c_rx_sequencer;

    typedef struct packed {
        logic        isErr;
        logic [23:0] frame;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        masterScl;
    logic        masterSda;
    logic        sdaLine;
    logic        sda_drive_out;
    logic [23:0] frame_out;
    logic        frame_valid_out;
    logic        frame_err_out;
    logic        busy_out;

    int          checks;
    int          failures;
    int          ackPulses;
    logic        busySeen;
    logic        prevDrive;
    logic [23:0] lastFrame;
    exp_t        expQ[$];

    assign sdaLine = masterSda & ~sda_drive_out;

    i2c_rx_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .scl_in         (masterScl),
        .sda_in         (sdaLine),
        .sda_drive_out  (sda_drive_out),
        .frame_out      (frame_out),
        .frame_valid_out(frame_valid_out),
        .frame_err_out  (frame_err_out),
        .busy_out       (busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: counts ACK pulses and matches every frame/abort pulse against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevDrive = 1'b0;
        end else begin
            if (sda_drive_out && !prevDrive) ackPulses++;
            prevDrive = sda_drive_out;
            if (busy_out) busySeen = 1'b1;
            if (frame_valid_out || frame_err_out) begin
                exp_t e;
                checks++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_pulse: got valid=%0b err=%0b frame=%h, required no pulse",
                             frame_valid_out, frame_err_out, frame_out);
                end else begin
                    e = expQ.pop_front();
                    if (frame_err_out !== e.isErr || frame_valid_out !== !e.isErr || frame_out !== e.frame) begin
                        failures++;
                        $display("[TB] FAIL pulse_match: got valid=%0b err=%0b frame=%h, required valid=%0b err=%0b frame=%h",
                                 frame_valid_out, frame_err_out, frame_out, !e.isErr, e.isErr, e.frame);
                    end
                end
            end
        end
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2cStart;
        if (!masterScl) begin
            masterSda = 1'b1;
            waitClk(10);
            masterScl = 1'b1;
            waitClk(10);
        end
        masterSda = 1'b0;
        waitClk(10);
        masterScl = 1'b0;
        waitClk(10);
    endtask

    task automatic i2cStop;
        masterSda = 1'b0;
        waitClk(10);
        masterScl = 1'b1;
        waitClk(10);
        masterSda = 1'b1;
        waitClk(20);
    endtask

    task automatic sendBits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            masterSda = b[i];
            waitClk(10);
            masterScl = 1'b1;
            waitClk(20);
            masterScl = 1'b0;
            waitClk(10);
        end
    endtask

    task automatic ackClock(output logic acked);
        masterSda = 1'b1;
        waitClk(10);
        masterScl = 1'b1;
        waitClk(10);
        acked = (sdaLine == 1'b0);
        waitClk(10);
        masterScl = 1'b0;
        waitClk(10);
    endtask

    task automatic writeByte(input logic [7:0] b, input logic expAck);
        logic acked;
        sendBits(b);
        ackClock(acked);
        checks++;
        if (acked !== expAck) begin
            failures++;
            $display("[TB] FAIL ack_%h: got ack=%0b, required ack=%0b", b, acked, expAck);
        end
    endtask

    task automatic drainCheck(input string name);
        for (int i = 0; i < 100 && expQ.size() != 0; i++) waitClk(1);
        waitClk(5);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s_pending: got %0d pulses outstanding, required 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    task automatic runFrame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        i2cStart();
        writeByte(8'h94, 1'b1);
        writeByte(b0, 1'b1);
        writeByte(b1, 1'b1);
        writeByte(b2, 1'b1);
        lastFrame = {b0, b1, b2};
        expQ.push_back('{isErr: 1'b0, frame: lastFrame});
        i2cStop();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        masterScl = 1'b1;
        masterSda = 1'b1;
        waitClk(5);
        checks++;
        if ({sda_drive_out, frame_valid_out, frame_err_out, busy_out, frame_out} !== 28'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got drive=%0b valid=%0b err=%0b busy=%0b frame=%h, required all 0",
                     sda_drive_out, frame_valid_out, frame_err_out, busy_out, frame_out);
        end
        rst_n = 1'b1;
        waitClk(10);
        checks++;
        if ({sda_drive_out, frame_valid_out, frame_err_out, busy_out, frame_out} !== 28'h0) begin
            failures++;
            $display("[TB] FAIL idle_outputs: got drive=%0b valid=%0b err=%0b busy=%0b frame=%h, required all 0",
                     sda_drive_out, frame_valid_out, frame_err_out, busy_out, frame_out);
        end
    endtask

    task automatic test_full_frame;
        ackPulses = 0;
        i2cStart();
        writeByte(8'h94, 1'b1);
        checks++;
        if (busy_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL busy_after_addr: got %0b, required 1", busy_out);
        end
        writeByte(8'h12, 1'b1);
        writeByte(8'h34, 1'b1);
        writeByte(8'h56, 1'b1);
        lastFrame = 24'h123456;
        expQ.push_back('{isErr: 1'b0, frame: lastFrame});
        i2cStop();
        drainCheck("full_frame");
        checks++;
        if (ackPulses != 4) begin
            failures++;
            $display("[TB] FAIL full_frame_acks: got %0d ACK pulses, required 4", ackPulses);
        end
        checks++;
        if (busy_out !== 1'b0 || frame_out !== 24'h123456) begin
            failures++;
            $display("[TB] FAIL full_frame_final: got busy=%0b frame=%h, required busy=0 frame=123456",
                     busy_out, frame_out);
        end
    endtask

    task automatic test_addr_reject;
        ackPulses = 0;
        busySeen  = 1'b0;
        i2cStart();
        writeByte(8'h96, 1'b0);
        i2cStart();
        writeByte(8'h92, 1'b0);
        i2cStop();
        drainCheck("addr_reject");
        checks++;
        if (ackPulses != 0 || busySeen !== 1'b0) begin
            failures++;
            $display("[TB] FAIL addr_reject_bus: got ackPulses=%0d busySeen=%0b, required 0 and 0",
                     ackPulses, busySeen);
        end
    endtask

    task automatic test_short_frame;
        i2cStart();
        writeByte(8'h94, 1'b1);
        writeByte(8'hAA, 1'b1);
        expQ.push_back('{isErr: 1'b1, frame: lastFrame});
        i2cStop();
        drainCheck("short_frame");
        checks++;
        if (frame_out !== lastFrame) begin
            failures++;
            $display("[TB] FAIL short_frame_keep: got frame=%h, required %h", frame_out, lastFrame);
        end
    endtask

    task automatic test_repeated_start;
        i2cStart();
        writeByte(8'h94, 1'b1);
        writeByte(8'h01, 1'b1);
        expQ.push_back('{isErr: 1'b1, frame: lastFrame});
        runFrame(8'h0A, 8'h0B, 8'h0C);
        drainCheck("repeated_start");
    endtask

    task automatic test_extra_byte;
        ackPulses = 0;
        i2cStart();
        writeByte(8'h94, 1'b1);
        writeByte(8'h11, 1'b1);
        writeByte(8'h22, 1'b1);
        writeByte(8'h33, 1'b1);
        writeByte(8'hFF, 1'b0);
        lastFrame = 24'h112233;
        expQ.push_back('{isErr: 1'b0, frame: lastFrame});
        i2cStop();
        drainCheck("extra_byte");
        checks++;
        if (ackPulses != 4) begin
            failures++;
            $display("[TB] FAIL extra_byte_acks: got %0d ACK pulses, required 4", ackPulses);
        end
    endtask

    task automatic test_reset_midframe;
        logic acked;
        i2cStart();
        writeByte(8'h94, 1'b1);
        sendBits(8'h12);
        masterSda = 1'b1;
        waitClk(10);
        checks++;
        if (sda_drive_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midframe_ack_on: got drive=%0b, required 1", sda_drive_out);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sda_drive_out, frame_valid_out, frame_err_out, busy_out, frame_out} !== 28'h0) begin
            failures++;
            $display("[TB] FAIL midframe_async_clear: got drive=%0b valid=%0b err=%0b busy=%0b frame=%h, required all 0",
                     sda_drive_out, frame_valid_out, frame_err_out, busy_out, frame_out);
        end
        lastFrame = 24'h0;
        masterScl = 1'b1;
        masterSda = 1'b1;
        waitClk(5);
        rst_n = 1'b1;
        waitClk(10);
        acked = 1'b0;
        runFrame(8'h12, 8'h34, 8'h56);
        drainCheck("after_reset");
        checks++;
        if (frame_out !== 24'h123456 || acked !== 1'b0) begin
            failures++;
            $display("[TB] FAIL after_reset_frame: got frame=%h, required 123456", frame_out);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] b[6];
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom_range(0, 255));
        runFrame(b[0], b[1], b[2]);
        runFrame(b[3], b[4], b[5]);
        drainCheck("back_to_back");
        checks++;
        if (frame_out !== {b[3], b[4], b[5]}) begin
            failures++;
            $display("[TB] FAIL back_to_back_frame: got frame=%h, required %h", frame_out, {b[3], b[4], b[5]});
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        ackPulses = 0;
        busySeen  = 1'b0;
        prevDrive = 1'b0;
        lastFrame = 24'h0;
        rst_n     = 1'b0;
        masterScl = 1'b1;
        masterSda = 1'b1;
        test_reset();
        test_full_frame();
        test_addr_reject();
        test_short_frame();
        test_repeated_start();
        test_extra_byte();
        test_reset_midframe();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
